// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the debounce block and the multi-button wrapper
// that reuses it.
//   ST_STABLE / ST_PENDING    : FSM state encodings
//   DEFAULT_STABLE_CYCLES     : default qualification length in cycles
//   state_e                   : typed FSM state built on the encodings
package debounce_pkg;

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  localparam int DEFAULT_STABLE_CYCLES = 4;

  typedef enum logic {
    S_STABLE  = ST_STABLE,
    S_PENDING = ST_PENDING
  } state_e;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit. Only q should be
// used by downstream logic; the first stage may go metastable.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, both stages clear to 0
//   d   : asynchronous input
//   q   : synchronized output, two cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule : sync_2ff

// File: rtl/debounce_pulse.sv
// debounce_pulse
// Turns a raw, possibly bouncing button/switch input into a clean
// registered level plus its complement and single-cycle edge pulses.
// The synchronized input must differ from q for STABLE_CYCLES consecutive
// cycles before q follows it; any bounce back restarts qualification.
// Parameters:
//   STABLE_CYCLES : qualification length, 1..65535
//   CNT_W         : counter width, derived from STABLE_CYCLES (do not override)
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   d_in  : raw asynchronous input
//   q     : debounced level (registered)
//   q_bar : complement of q (registered alongside q)
//   rise  : one-cycle pulse when q goes 0->1
//   fall  : one-cycle pulse when q goes 1->0
//   busy  : high while a change is being qualified
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q,
  output logic q_bar,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s2;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_bar_q;
  logic             rise_q;
  logic             fall_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d_in),
    .q   (s2)
  );

  // Single registered FSM. The level, its complement and the pulses are all
  // written in the same commit branch so q_bar can never disagree with q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_STABLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_bar_q <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_STABLE: begin
          if (s2 != level_q) begin
            if (STABLE_CYCLES == 1) begin
              // A single differing sample is already enough to qualify.
              level_q     <= s2;
              level_bar_q <= ~s2;
              rise_q      <= s2;
              fall_q      <= ~s2;
            end else begin
              cnt_q   <= CNT_ONE;
              state_q <= S_PENDING;
            end
          end
        end
        S_PENDING: begin
          if (s2 == level_q) begin
            // Bounced back before qualifying: discard the change.
            cnt_q   <= '0;
            state_q <= S_STABLE;
          end else if (cnt_q == CNT_LAST) begin
            level_q     <= s2;
            level_bar_q <= ~s2;
            rise_q      <= s2;
            fall_q      <= ~s2;
            cnt_q       <= '0;
            state_q     <= S_STABLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_STABLE;
        end
      endcase
    end
  end

  assign q     = level_q;
  assign q_bar = level_bar_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  // busy comes straight off the state flop, so it is registered too.
  assign busy  = (state_q == S_PENDING);

endmodule : debounce_pulse

// File: doc/debounce_pulse.md
# debounce_pulse

Conditions a raw, asynchronous, possibly bouncing single-bit input (push-button or switch) into a clean registered level with complementary output and single-cycle edge pulses. Sits directly upstream of the D flip-flop stages: its `q` output is the clean `d` those flops sample. It contains a two-flop synchronizer, a stability counter and a two-state FSM.

## Interface
- `STABLE_CYCLES`, default 4: consecutive cycles the synchronized input must differ from `q` before `q` follows it. Legal range is 1..65535.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: counter width. This is derived and must not be overridden.

Ports:
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  reset, asynchronous and active-high; asserts immediately, released synchronously by the source.
- `d_in`  input  1  raw asynchronous input.
- `q`  output  1  debounced level, registered.
- `q_bar`  output  1  always `~q`, registered. It must never differ from `~q`, including during reset.
- `rise`  output  1  one-cycle pulse, coincident with `q` going 0→1.
- `fall`  output  1  one-cycle pulse, coincident with `q` going 1→0.
- `busy`  output  1  high while the FSM is in `PENDING`.

## Operation
- **Synchronizer:** `s1 <= d_in`, then `s2 <= s1`. Only `s2` is used downstream.
- **FSM states:**
  - `STABLE`: `cnt` = 0.
  - `PENDING`: `1 <= cnt <= STABLE_CYCLES-1`.
- **In `STABLE`:**
  - If `s2 == q`, hold.
  - If `s2 != q` and `STABLE_CYCLES == 1`, commit: `q <= s2`, pulse, stay in `STABLE`.
  - Otherwise, `cnt <= 1` and go to `PENDING`.
- **In `PENDING`:**
  - If `s2 == q` (bounce back), `cnt <= 0` and go to `STABLE`. No pulse and no `q` change.
  - Else if `cnt == STABLE_CYCLES-1`, commit: `q <= s2`, `cnt <= 0`, go to `STABLE`.
  - Else `cnt <= cnt + 1`.
- **Commit:** `rise <= s2` and `fall <= ~s2` for exactly that one cycle. Otherwise `rise` and `fall` are 0. `rise` and `fall` are never high together.
- **Counter width:** `cnt` never exceeds `STABLE_CYCLES-1`, so no wrap is possible. No saturation logic is needed beyond the compare.
- **Reset values:** `s1`=0, `s2`=0, `q`=0, `q_bar`=1, `rise`=0, `fall`=0, `busy`=0, `cnt`=0, state=`STABLE`.
- **Reset mid-operation:** all of the above take effect immediately, even mid-`PENDING` or during a pulse cycle. A pending change is discarded.
- **After reset release while `d_in`=1:** this is treated as a normal 0→1 change. `rise` fires after the full latency.

## Timing
- **Latency:** let edge k be the first rising edge sampling a new `d_in` value that then holds. `s2` updates at k+1, and `q`, `q_bar` and `rise`/`fall` update at edge k+1+`STABLE_CYCLES`.
  - With the default of 4, that is edge k+5.
  - With `STABLE_CYCLES`=1, that is edge k+2.
- **Glitch rejection:**
  - A change visible on `s2` for fewer than `STABLE_CYCLES` consecutive cycles never reaches `q`.
  - A change visible for exactly `STABLE_CYCLES` cycles does reach `q`.
- **`busy` timing:** `busy` rises the edge after `s2` first differs from `q`. It falls on the commit edge or the bounce-back edge.
- **Back-to-back toggles:** the minimum spacing between two commits is `STABLE_CYCLES` cycles. The FSM re-enters `PENDING` the edge after a commit if `s2` already differs again.
- **Registered outputs:** all outputs are registered. There are no combinational paths from `d_in`.

## Structure
- **Shared package `debounce_pkg`:**
  - State encoding localparams `ST_STABLE`=1'b0 and `ST_PENDING`=1'b1.
  - Default `STABLE_CYCLES` constant.
  - Both are reused by the later multi-button wrapper.
- **Sub-module `sync_2ff`:**
  - A two-flop synchronizer with `clk`, `rst`, `d`, `q`.
  - Reset value 0.
  - Instantiated once here and reusable elsewhere.
- **Remaining logic:** FSM, counter and output registers live in `debounce_pulse` itself.

## Test plan
All scenarios use a 10 ns clock and `STABLE_CYCLES`=4 unless stated.
- **Reset:** hold `rst`=1 for 3 cycles with `d_in`=1 → `q`=0, `q_bar`=1, `rise`=`fall`=`busy`=0 throughout. After release, `rise` pulses once at edge 6 after release and `q`=1 from then on.
- **Clean press:** `d_in` 0→1 sampled at edge k → `busy`=1 at k+2..k+4, `q`=1 and `rise`=1 at k+5, `rise`=0 at k+6. `fall` stays 0.
- **Bounce:** `d_in` = 1 for 2 cycles, 0 for 1, 1 for 3, then 0 → `q` stays 0, with no `rise` or `fall`. Then hold 1 for 6 cycles → exactly one `rise`.
- **Release and timing boundary:** `q`=1, then `d_in`→0 held → `fall`=1 for one cycle at k+5 and `q_bar`=1. A low lasting exactly 4 cycles commits; a low lasting 3 cycles does not.
- **Reset mid-PENDING:** assert `rst` at k+3 of a 0→1 change → `q`=0 and `busy`=0 immediately. No pulse appears during or after reset until a fresh 5-edge qualification completes.
- **Minimum setting:** with `STABLE_CYCLES`=1, a toggle held for 1 cycle at edge k → `q` updates at k+2 with a one-cycle pulse and `busy` never asserts.
